// File: rtl/nn_pkg.sv
// Shared types and fixed-point constants for the training sequencer and its trainer.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } seq_state_t;

    localparam logic [31:0] FP_ONE = 32'h0001_0000;

    // AND truth table: bit i set means entry i carries FP_ONE in that column.
    localparam logic [3:0] AND_X1_MASK = 4'b1100;
    localparam logic [3:0] AND_X2_MASK = 4'b1010;
    localparam logic [3:0] AND_Y_MASK  = 4'b1000;

    function automatic logic [31:0] and_entry(input logic [3:0] mask, input int idx);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (idx == i && mask[i]) v = FP_ONE;
        end
        return v;
    endfunction

endpackage

// File: rtl/train_sample_sequencer_if.sv
// Sample stream bundle between the sequencer (master) and the trainer (slave).
interface train_sample_sequencer_if #(
    parameter int W     = 32,
    parameter int IDX_W = 3
);
    // A sample transfers on every clock edge where valid and ready are both 1;
    // while valid is 1 and ready is 0 the sample and its tags are held unchanged.
    logic             start;
    logic             ready;
    logic             valid;
    logic [W-1:0]     x1;
    logic [W-1:0]     x2;
    logic [W-1:0]     y;
    logic [IDX_W-1:0] sample_idx;
    logic [7:0]       epoch;
    logic             last;
    logic             done;

    modport master (
        input  start, ready,
        output valid, x1, x2, y, sample_idx, epoch, last, done
    );

    modport slave (
        output start, ready,
        input  valid, x1, x2, y, sample_idx, epoch, last, done
    );
endinterface

// File: rtl/train_sample_sequencer.sv
// Streams the training table NUM_SAMPLES x TRAIN_ITERATIONS times under valid/ready.
// Optional feature: SEQ_LOAD_EN adds a table write port usable outside STREAM.
module train_sample_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_SAMPLES      = 4,
    parameter int TRAIN_ITERATIONS = 10,
    parameter int SIGN             = 1,
    parameter int Q_M              = 15,
    parameter int Q_N              = 16,
    localparam int W               = SIGN + Q_M + Q_N,
    localparam int IDX_W           = $clog2(NUM_SAMPLES) + 1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             ready_i,
`ifdef SEQ_LOAD_EN
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_addr_i,
    input  logic [W-1:0]     wr_x1_i,
    input  logic [W-1:0]     wr_x2_i,
    input  logic [W-1:0]     wr_y_i,
`endif
    output logic             valid_o,
    output logic [W-1:0]     train_x1_o,
    output logic [W-1:0]     train_x2_o,
    output logic [W-1:0]     train_out_o,
    output logic [IDX_W-1:0] sample_idx_o,
    output logic [7:0]       epoch_o,
    output logic             last_o,
    output logic             done_o,
    output seq_state_t       state_o
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [7:0]       LAST_EPOCH = 8'(TRAIN_ITERATIONS - 1);

    seq_state_t       state, state_n;
    logic             valid_q, valid_n, last_q, last_n, done_q, done_n, load;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [7:0]       epoch_q, epoch_n;
    logic [W-1:0]     x1_q, x1_n, x2_q, x2_n, y_q, y_n;

    logic [W-1:0] tab_x1 [NUM_SAMPLES];
    logic [W-1:0] tab_x2 [NUM_SAMPLES];
    logic [W-1:0] tab_y  [NUM_SAMPLES];

`ifdef SEQ_LOAD_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < NUM_SAMPLES; i++) begin
                tab_x1[i] <= W'(and_entry(AND_X1_MASK, i));
                tab_x2[i] <= W'(and_entry(AND_X2_MASK, i));
                tab_y[i]  <= W'(and_entry(AND_Y_MASK, i));
            end
        end else if (wr_en_i && state != STREAM && wr_addr_i < IDX_W'(NUM_SAMPLES)) begin
            for (int i = 0; i < NUM_SAMPLES; i++) begin
                if (wr_addr_i == IDX_W'(i)) begin
                    tab_x1[i] <= wr_x1_i;
                    tab_x2[i] <= wr_x2_i;
                    tab_y[i]  <= wr_y_i;
                end
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            tab_x1[i] = W'(and_entry(AND_X1_MASK, i));
            tab_x2[i] = W'(and_entry(AND_X2_MASK, i));
            tab_y[i]  = W'(and_entry(AND_Y_MASK, i));
        end
    end
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            epoch_q <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            y_q     <= '0;
        end else begin
            state   <= state_n;
            valid_q <= valid_n;
            last_q  <= last_n;
            done_q  <= done_n;
            idx_q   <= idx_n;
            epoch_q <= epoch_n;
            x1_q    <= x1_n;
            x2_q    <= x2_n;
            y_q     <= y_n;
        end
    end

    always_comb begin
        state_n = state;
        valid_n = valid_q;
        last_n  = last_q;
        done_n  = done_q;
        idx_n   = idx_q;
        epoch_n = epoch_q;
        load    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    state_n = STREAM;
                    valid_n = 1'b1;
                    done_n  = 1'b0;
                    idx_n   = '0;
                    epoch_n = '0;
                    last_n  = (LAST_IDX == '0) && (LAST_EPOCH == 8'd0);
                    load    = 1'b1;
                end
            end
            STREAM: begin
                if (ready_i) begin
                    if (last_q) begin
                        state_n = DONE;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        if (idx_q == LAST_IDX) begin
                            idx_n   = '0;
                            epoch_n = epoch_q + 8'd1;
                        end else begin
                            idx_n = idx_q + IDX_W'(1);
                        end
                        last_n = (idx_n == LAST_IDX) && (epoch_n == LAST_EPOCH);
                        load   = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Data registers capture the next sample on the same edge as its index.
        x1_n = x1_q;
        x2_n = x2_q;
        y_n  = y_q;
        if (load) begin
            for (int i = 0; i < NUM_SAMPLES; i++) begin
                if (idx_n == IDX_W'(i)) begin
                    x1_n = tab_x1[i];
                    x2_n = tab_x2[i];
                    y_n  = tab_y[i];
                end
            end
        end
    end

    assign valid_o      = valid_q;
    assign train_x1_o   = x1_q;
    assign train_x2_o   = x2_q;
    assign train_out_o  = y_q;
    assign sample_idx_o = idx_q;
    assign epoch_o      = epoch_q;
    assign last_o       = last_q;
    assign done_o       = done_q;
    assign state_o      = state;

endmodule

// File: doc/train_sample_sequencer.md
TRAIN_SAMPLE_SEQUENCER -- requirements
Module: train_sample_sequencer

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default 4, number of samples in the training set (1..16).
REQ-002 SHALL have parameter TRAIN_ITERATIONS, default 10, number of passes (epochs) over the set (1..255).
REQ-003 SHALL have parameters SIGN, Q_M and Q_N, defaults 1, 15 and 16, the fixed-point word format; W = SIGN+Q_M+Q_N.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start_i, input, 1 bit: single-cycle request to begin a training run.
REQ-007 SHALL have port ready_i, input, 1 bit: the downstream trainer accepts the current sample.
REQ-008 SHALL have port valid_o, output, 1 bit: a sample is presented.
REQ-009 SHALL have ports train_x1_o, train_x2_o and train_out_o, outputs, W bits each: the inputs and target of the current sample.
REQ-010 SHALL have port sample_idx_o, output, $clog2(NUM_SAMPLES)+1 bits: index of the presented sample.
REQ-011 SHALL have port epoch_o, output, 8 bits: index of the current epoch, counting from 0.
REQ-012 SHALL have port last_o, output, 1 bit: the presented sample is the final sample of the final epoch.
REQ-013 SHALL have port done_o, output, 1 bit: the run is complete.

Function
REQ-014 SHALL implement a finite state machine with states IDLE, STREAM and DONE.
REQ-015 SHALL go from IDLE to STREAM when start_i=1, with valid_o=1, sample_idx_o=0 and epoch_o=0 on the following cycle (latency of 1 cycle).
REQ-016 SHALL count a transfer on every cycle with valid_o=1 and ready_i=1.
REQ-017 SHALL hold valid_o and all data outputs stable while valid_o=1 and ready_i=0.
REQ-018 SHALL, on a transfer, advance sample_idx_o by one.
REQ-019 SHALL, on a transfer where sample_idx_o=NUM_SAMPLES-1, wrap sample_idx_o to 0 and increment epoch_o.
REQ-020 SHALL, on a transfer with last_o=1, enter DONE with valid_o=0 and done_o=1 on the next cycle.
REQ-021 SHALL keep valid_o=1 continuously between transfers; back-to-back transfers deliver one sample per cycle with no bubble.
REQ-022 SHALL ignore start_i in STREAM.
REQ-023 SHALL, on start_i=1 in DONE, clear done_o and restart exactly as from IDLE.
REQ-024 SHALL drive all outputs from registers.
REQ-025 SHALL hold the sample table in NUM_SAMPLES entries of {x1, x2, target}, W bits each.
REQ-026 SHALL load the table on reset with the AND truth table over indices 0..3: (0,0,0), (0,0x00010000,0), (0x00010000,0,0), (0x00010000,0x00010000,0x00010000).
REQ-027 SHALL load any entries at index 4 and above with 0.
REQ-028 SHALL, with NUM_SAMPLES=1, assert last_o on the first sample when TRAIN_ITERATIONS=1.

Reset
REQ-029 SHALL, while reset_ni=0, force state IDLE, valid_o=0, done_o=0, last_o=0, sample_idx_o=0, epoch_o=0, all data outputs to 0, and the table to its default contents.
REQ-030 SHALL, on reset in mid-STREAM, drop valid_o within the same cycle as reset assertion, and emit no sample until a new start_i.

Configuration
REQ-031 SHALL, with macro SEQ_LOAD_EN defined, add ports wr_en_i (1 bit), wr_addr_i ($clog2(NUM_SAMPLES)+1 bits) and wr_x1_i, wr_x2_i, wr_y_i (W bits each).
REQ-032 SHALL, with SEQ_LOAD_EN defined, write the table entry on wr_en_i=1 only in IDLE or DONE.
REQ-033 SHALL, with SEQ_LOAD_EN defined, ignore writes in STREAM and writes with wr_addr_i>=NUM_SAMPLES.
REQ-034 SHALL, with SEQ_LOAD_EN undefined, omit the write ports and make the table a constant ROM.

Structure
REQ-035 SHALL take the state enum type, the fixed-point 1.0 constant (0x00010000) and the default truth-table constants from a shared package, nn_pkg, also used by the trainer.
REQ-036 SHALL be one module with no sub-modules; the table is an inferred register array.

Verification
REQ-037 Bench SHALL check: defaults, ready_i held 1, start_i pulse -> 40 transfers; epoch_o runs 0..9; last_o only on transfer 40; done_o=1 one cycle later.
REQ-038 Bench SHALL check: ready_i low for 3 cycles at sample 2 -> train_x1_o=0x00010000, train_x2_o=0, train_out_o=0 stay stable, with no index advance.
REQ-039 Bench SHALL check: reset_ni pulsed low at epoch 5 -> valid_o=0 immediately; after release, nothing is emitted until start_i, then sample 0 of epoch 0.
REQ-040 Bench SHALL check: start_i in DONE -> done_o cleared and a full run of 40 transfers again.
REQ-041 Bench SHALL check: with SEQ_LOAD_EN, write index 3 target 0 in IDLE, then run -> sample 3 shows target 0; the same write during STREAM has no effect.
REQ-042 Bench SHALL check: NUM_SAMPLES=1 and TRAIN_ITERATIONS=1 -> exactly one transfer, with last_o=1 on it.
